// File: rtl/pc_next_gen.sv
// Next-PC sequencer: boot fetch, control-flow priority select and a
// circular return-address stack feeding the PC register's D input.
module pc_next_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

  typedef enum logic {BOOT, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             push;
  logic [PW-1:0]    top_idx;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] jt_al;
  logic [WIDTH-1:0] bt_al;

  // ptr_q is the next free slot; the top entry sits just below it.
  assign top_idx = ptr_q - PW'(1);
  assign pc_inc  = pc + WIDTH'(4);
  assign ras_top = ras_q[top_idx] & ALIGN;
  assign jt_al   = jump_target & ALIGN;
  assign bt_al   = branch_target & ALIGN;

  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CW'(RAS_DEPTH));
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    push    = 1'b0;
    pc_next = pc_inc;

    if (state_q == BOOT) begin
      pc_next = RESET_VECTOR;
      if (!stall) state_d = RUN;
    end else begin
      priority case (1'b1)
        stall: pc_next = pc;
        ret && call: begin
          pc_next = ras_empty ? jt_al : ras_top;
          if (ras_empty) begin
            push  = 1'b1;
            udf_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end
        end
        ret: begin
          if (ras_empty) begin
            udf_d = 1'b1;
          end else begin
            pc_next = ras_top;
            ptr_d   = top_idx;
            cnt_d   = cnt_q - CW'(1);
          end
        end
        call: begin
          pc_next = jt_al;
          push    = 1'b1;
        end
        jump:         pc_next = jt_al;
        branch_taken: pc_next = bt_al;
        default:      pc_next = pc_inc;
      endcase
    end

    // A push when full lands on the oldest slot, which ptr_q has wrapped onto.
    if (push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PW'(1);
      if (ras_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      if (wr_en) ras_q[wr_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_next_gen.sv
// Directed bench for pc_next_gen: boot, priority, RAS push/pop,
// overflow/underflow, tail-return, wrap, alignment and async reset.
module tb_pc_next_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        call;
  logic [31:0] jump_target;
  logic        ret;
  logic [31:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;

  int errors = 0;
  int checks = 0;

  pc_next_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .call          (call),
    .jump_target   (jump_target),
    .ret           (ret),
    .pc_next       (pc_next),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_ret [4];

  initial begin
    exp_ret[0] = 32'h14; exp_ret[1] = 32'h10;
    exp_ret[2] = 32'hC;  exp_ret[3] = 32'h8;
    rst_n = 0; pc = '0; idle();
    #3;
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
    chk("rst_ovf", 32'(ras_overflow), 32'd0);
    chk("rst_udf", 32'(ras_underflow), 32'd0);

    #9 rst_n = 1; stall = 1;
    #1 chk("boot_pc_next", pc_next, 32'h0);
    tick();
    stall = 0;
    #1 chk("boot_stall_hold", pc_next, 32'h0);
    tick();
    pc = 32'h10;
    #1 chk("run_seq", pc_next, 32'h14);

    pc = 32'h20; branch_taken = 1; branch_target = 32'h100;
    jump = 1; jump_target = 32'h200;
    #1 chk("prio_jump", pc_next, 32'h200);
    stall = 1;
    #1 chk("prio_stall", pc_next, 32'h20);
    stall = 0; jump = 0;
    #1 chk("prio_branch", pc_next, 32'h100);
    idle();

    pc = 32'h40; call = 1; jump_target = 32'h400;
    #1 chk("call_target", pc_next, 32'h400);
    tick(); idle();
    chk("call_nonempty", 32'(ras_empty), 32'd0);
    pc = 32'h420; ret = 1;
    #1 chk("ret_addr", pc_next, 32'h44);
    tick(); idle();
    chk("ret_empty", 32'(ras_empty), 32'd1);
    chk("ret_no_udf", 32'(ras_underflow), 32'd0);

    for (int i = 0; i < 5; i++) begin
      pc = 32'(i * 4); call = 1; jump_target = 32'h1000;
      tick();
      if (i == 3) begin
        chk("full4", 32'(ras_full), 32'd1);
        chk("no_ovf4", 32'(ras_overflow), 32'd0);
      end
    end
    idle();
    chk("ovf_full", 32'(ras_full), 32'd1);
    chk("ovf_flag", 32'(ras_overflow), 32'd1);

    pc = 32'h1000; ret = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("ovf_ret%0d", i), pc_next, exp_ret[i]);
      tick();
    end
    pc = 32'h2000;
    #1 chk("udf_ret", pc_next, 32'h2004);
    tick(); idle();
    chk("udf_flag", 32'(ras_underflow), 32'd1);
    chk("udf_empty", 32'(ras_empty), 32'd1);

    pc = 32'hFFFF_FFFC;
    #1 chk("wrap", pc_next, 32'h0);
    pc = 32'h80; jump = 1; jump_target = 32'h103;
    #1 chk("align_jump", pc_next, 32'h100);
    jump = 0; branch_taken = 1; branch_target = 32'h207;
    #1 chk("align_branch", pc_next, 32'h204);
    idle();

    pc = 32'h50; call = 1; jump_target = 32'h500;
    tick();
    pc = 32'h500; call = 1; ret = 1; jump_target = 32'h600;
    #1 chk("tail_ret", pc_next, 32'h54);
    tick(); idle();
    pc = 32'h600; ret = 1;
    #1 chk("tail_top", pc_next, 32'h504);
    tick(); idle();
    chk("tail_empty", 32'(ras_empty), 32'd1);

    pc = 32'h30; stall = 1; call = 1; jump_target = 32'h700;
    #1 chk("stall_call", pc_next, 32'h30);
    tick(); idle();
    chk("stall_no_push", 32'(ras_empty), 32'd1);

    pc = 32'h60; call = 1; jump_target = 32'h800;
    tick();
    pc = 32'h70;
    tick(); idle();
    pc = 32'h80;
    #2 rst_n = 0;
    #1;
    chk("midrst_empty", 32'(ras_empty), 32'd1);
    chk("midrst_pc_next", pc_next, 32'h0);
    chk("midrst_ovf", 32'(ras_overflow), 32'd0);
    chk("midrst_udf", 32'(ras_underflow), 32'd0);
    #10 rst_n = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
